// File: rtl/guia_05_pkg.sv
// Shared definitions for the guia_05 serial blocks: FSM state encoding and
// default frame geometry.
package guia_05_pkg;

   localparam int DATA_W_DEF       = 8;
   localparam int CLKS_PER_BIT_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

endpackage : guia_05_pkg

// File: rtl/guia_0508_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and emits a
// one-cycle tick on the wrap cycle; parked at zero when disabled.
module guia_0508_baud
   import guia_05_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int                CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!en || (cnt_q == CNT_MAX)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = en && (cnt_q == CNT_MAX);

endmodule : guia_0508_baud

// File: rtl/guia_0508_parity_tx.sv
// UART-style transmitter with parity: start(0), DATA_W bits LSB first,
// parity, stop(1); each bit lasts CLKS_PER_BIT cycles. tx is registered.
module guia_0508_parity_tx
   import guia_05_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter bit ODD_PARITY   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              parity_q, parity_d;
   logic              tx_q, tx_d;
   logic              tick;

   assign ready = (state_q == ST_IDLE);
   assign busy  = !ready;
   assign done  = (state_q == ST_STOP) && tick;
   assign tx    = tx_q;

   guia_0508_baud #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (busy),
      .tick (tick)
   );

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      parity_d = parity_q;

      unique case (state_q)
         ST_IDLE: begin
            if (valid) begin
               state_d  = ST_START;
               shift_d  = data;
               idx_d    = '0;
               parity_d = ODD_PARITY ? ~^data : ^data;
            end
         end
         ST_START:  if (tick) state_d = ST_DATA;
         ST_DATA: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_PARITY;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end
         end
         ST_PARITY: if (tick) state_d = ST_STOP;
         ST_STOP:   if (tick) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // The line level is decoded from the next state so tx leaves a flop and
   // changes exactly on the edge that enters each bit.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = parity_d;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
      end
   end

endmodule : guia_0508_parity_tx

// File: tb/tb_guia_0508_parity_tx.sv
// Self-checking bench: three configurations (odd/4, even/4, odd/1) driven with
// directed and random payloads, compared cycle by cycle against a frame model.
module tb_guia_0508_parity_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data;
   logic       valid_m, valid_e, valid_f;
   logic       ready_m, tx_m, busy_m, done_m;
   logic       ready_e, tx_e, busy_e, done_e;
   logic       ready_f, tx_f, busy_f, done_f;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   guia_0508_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .data(data), .valid(valid_m),
      .ready(ready_m), .tx(tx_m), .busy(busy_m), .done(done_m));

   guia_0508_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) dut_e (
      .clk(clk), .rst_n(rst_n), .data(data), .valid(valid_e),
      .ready(ready_e), .tx(tx_e), .busy(busy_e), .done(done_e));

   guia_0508_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .ODD_PARITY(1'b1)) dut_f (
      .clk(clk), .rst_n(rst_n), .data(data), .valid(valid_f),
      .ready(ready_f), .tx(tx_f), .busy(busy_f), .done(done_f));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Bit k of the frame: 0 start, 1..8 payload LSB first, 9 parity, 10 stop.
   function automatic logic exp_bit(input int which, input logic [7:0] d, input int k);
      int  ones;
      bit  odd;
      ones = $countones(d);
      odd  = (which != 1);
      if (k == 0)  return 1'b0;
      if (k <= 8)  return d[k-1];
      if (k == 9)  return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      return 1'b1;
   endfunction

   task automatic drive(input int which, input logic v, input logic [7:0] d);
      data = d;
      case (which)
         0:       valid_m = v;
         1:       valid_e = v;
         default: valid_f = v;
      endcase
   endtask

   task automatic sample(input int which, output logic t, output logic b,
                         output logic r, output logic dn);
      case (which)
         0:       begin t = tx_m; b = busy_m; r = ready_m; dn = done_m; end
         1:       begin t = tx_e; b = busy_e; r = ready_e; dn = done_e; end
         default: begin t = tx_f; b = busy_f; r = ready_f; dn = done_f; end
      endcase
   endtask

   // Entered at the falling edge of an idle cycle; leaves at the falling edge
   // of the idle cycle that follows the frame.
   task automatic frame(input int which, input logic [7:0] d, input bit hold,
                        input logic [7:0] nd, input bit perturb);
      int   cpb;
      int   len;
      logic t, b, r, dn;
      cpb = (which == 2) ? 1 : 4;
      len = 11 * cpb;
      sample(which, t, b, r, dn);
      check("pre_ready", r, 1);
      drive(which, 1'b1, d);
      @(posedge clk);
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         sample(which, t, b, r, dn);
         check($sformatf("dut%0d d=%02h tx[%0d]", which, d, c), t, exp_bit(which, d, c / cpb));
         check($sformatf("dut%0d done[%0d]", which, c), dn, (c == len - 1));
         check("busy", b, 1);
         check("ready", r, 0);
         if (hold)
            drive(which, 1'b1, nd);
         else if (perturb && (c < len - 4))
            drive(which, 1'($urandom_range(0, 1)), 8'($urandom));
         else
            drive(which, 1'b0, 8'($urandom));
      end
      @(negedge clk);
      sample(which, t, b, r, dn);
      check("gap_tx", t, 1);
      check("gap_busy", b, 0);
      check("gap_ready", r, 1);
      check("gap_done", dn, 0);
   endtask

   initial begin
      logic t, b, r, dn;
      rst_n   = 1'b0;
      data    = 8'h00;
      valid_m = 1'b0;
      valid_e = 1'b0;
      valid_f = 1'b0;
      #12;
      for (int w = 0; w < 3; w++) begin
         sample(w, t, b, r, dn);
         check("rst_tx", t, 1);
         check("rst_busy", b, 0);
         check("rst_ready", r, 1);
         check("rst_done", dn, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed payloads on the default configuration.
      frame(0, 8'hA5, 1'b0, 8'h00, 1'b0);
      frame(0, 8'h07, 1'b0, 8'h00, 1'b0);
      frame(0, 8'hFF, 1'b0, 8'h00, 1'b0);

      // Back-to-back with valid held high.
      frame(0, 8'h3C, 1'b1, 8'hC3, 1'b0);
      frame(0, 8'hC3, 1'b0, 8'h00, 1'b0);

      // Inputs disturbed mid-frame; no extra frame may start afterwards.
      frame(0, 8'h96, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      sample(0, t, b, r, dn);
      check("no_extra_busy", b, 0);

      for (int i = 0; i < 5; i++)
         frame(0, 8'($urandom), 1'b0, 8'h00, 1'($urandom_range(0, 1)));

      // Reset pulsed during payload bit 3 (cycles 16..19 of the frame).
      drive(0, 1'b1, 8'h3A);
      @(posedge clk);
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         if (c == 0) drive(0, 1'b0, 8'h00);
      end
      sample(0, t, b, r, dn);
      check("pre_rst_tx", t, exp_bit(0, 8'h3A, 4));
      rst_n = 1'b0;
      #1;
      sample(0, t, b, r, dn);
      check("async_rst_tx", t, 1);
      check("async_rst_busy", b, 0);
      check("async_rst_ready", r, 1);
      check("async_rst_done", dn, 0);
      @(negedge clk);
      sample(0, t, b, r, dn);
      check("held_rst_done", dn, 0);
      rst_n = 1'b1;
      @(negedge clk);
      frame(0, 8'h55, 1'b0, 8'h00, 1'b0);

      // Even parity configuration.
      frame(1, 8'h07, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++)
         frame(1, 8'($urandom), 1'b0, 8'h00, 1'($urandom_range(0, 1)));

      // Single-cycle bit period.
      frame(2, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++)
         frame(2, 8'($urandom), 1'b0, 8'h00, 1'($urandom_range(0, 1)));
      frame(2, 8'h81, 1'b1, 8'h7E, 1'b0);
      frame(2, 8'h7E, 1'b0, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_guia_0508_parity_tx
